// File: rtl/bus_trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_trace_capture_if
// Purpose  : Bundles the snooped buses, the trigger/arm controls and the
//            valid/ready pop port of bus_trace_capture.
// Modports : master - bus source / host side (drives buses, controls, rd_ready)
//            slave  - the capture block (drives rd_valid, rd_entry, state,
//                     level, overflow)
// Config   : BUS_TRACE_TIMESTAMP_EN widens each entry by a 16-bit timestamp.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_trace_capture_if #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16
);
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int c_ENTRY_W = 3 * WORD_W + 16;
`else
    localparam int c_ENTRY_W = 3 * WORD_W;
`endif
    localparam int c_LEVEL_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0]    read_bus;
    logic [WORD_W-1:0]    data_bus;
    logic [WORD_W-1:0]    write_bus;
    logic                 arm;
    logic                 disarm;
    logic [WORD_W-1:0]    trig_value;
    logic [WORD_W-1:0]    trig_mask;
    logic [15:0]          post_count;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [c_ENTRY_W-1:0] rd_entry;
    logic [1:0]           state;
    logic [c_LEVEL_W-1:0] level;
    logic                 overflow;

    modport master (
        output read_bus, data_bus, write_bus, arm, disarm,
               trig_value, trig_mask, post_count, rd_ready,
        input  rd_valid, rd_entry, state, level, overflow
    );

    modport slave (
        input  read_bus, data_bus, write_bus, arm, disarm,
               trig_value, trig_mask, post_count, rd_ready,
        output rd_valid, rd_entry, state, level, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bus_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : bus_trace_capture
// Purpose  : Triggered trace capture of read_bus/data_bus/write_bus into a
//            FIFO drained through a valid/ready pop port.
// Ports    : write_clk - sole clock (posedge)
//            rst_n     - synchronous active-low reset
//            bus       - bus_trace_capture_if.slave: snooped buses, arm/disarm,
//                        trigger value/mask, post_count, rd_valid/rd_ready/
//                        rd_entry pop port, state, level, overflow
// Config   : BUS_TRACE_TIMESTAMP_EN prepends a 16-bit free-running cycle
//            counter to every entry.
// Revision : 1.0 - initial release
// ============================================================================
module bus_trace_capture #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16
) (
    input  wire logic           write_clk,
    input  wire logic           rst_n,
    bus_trace_capture_if.slave  bus
);
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_LEVEL_W = c_PTR_W + 1;
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int c_ENTRY_W = 3 * WORD_W + 16;
`else
    localparam int c_ENTRY_W = 3 * WORD_W;
`endif

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ARMED     = 2'd1;
    localparam logic [1:0] c_CAPTURING = 2'd2;
    localparam logic [1:0] c_DONE      = 2'd3;

    logic [1:0]           r_state;
    logic [WORD_W-1:0]    r_trig_value;
    logic [WORD_W-1:0]    r_trig_mask;
    logic [15:0]          r_post_count;
    logic [15:0]          r_remaining;
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LEVEL_W-1:0] r_level;
    logic                 r_overflow;

    logic                 w_hit;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_store;
    logic [c_ENTRY_W-1:0] w_sample;

`ifdef BUS_TRACE_TIMESTAMP_EN
    logic [15:0] r_timestamp;

    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            r_timestamp <= 16'd0;
        end else begin
            r_timestamp <= r_timestamp + 16'd1;
        end
    end

    // Timestamp is the counter value seen at the capture edge.
    assign w_sample = {r_timestamp, bus.write_bus, bus.data_bus, bus.read_bus};
`else
    assign w_sample = {bus.write_bus, bus.data_bus, bus.read_bus};
`endif

    assign w_hit  = ((bus.write_bus ^ r_trig_value) & r_trig_mask) == '0;

    // disarm suppresses the push on its own edge, so an aborted run adds nothing.
    assign w_push = !bus.disarm &&
                    (((r_state == c_ARMED) && w_hit) || (r_state == c_CAPTURING));
    assign w_pop  = (r_level != '0) && bus.rd_ready;
    assign w_full = (r_level == c_LEVEL_W'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_store = w_push && (!w_full || w_pop);

    // Capture state machine and latched configuration.
    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_trig_value <= '0;
            r_trig_mask  <= '0;
            r_post_count <= 16'd0;
            r_remaining  <= 16'd0;
        end else if (bus.disarm) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.arm) begin
                        r_trig_value <= bus.trig_value;
                        r_trig_mask  <= bus.trig_mask;
                        r_post_count <= bus.post_count;
                        r_state      <= c_ARMED;
                    end
                end
                c_ARMED: begin
                    if (w_hit) begin
                        r_remaining <= r_post_count;
                        r_state     <= (r_post_count == 16'd0) ? c_DONE : c_CAPTURING;
                    end
                end
                c_CAPTURING: begin
                    // Dropped samples still consume a slot of the post-trigger window.
                    r_remaining <= r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Sticky overflow; arming starts a fresh run with it cleared.
    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (!bus.disarm && bus.arm &&
                     ((r_state == c_IDLE) || (r_state == c_DONE))) begin
            r_overflow <= 1'b0;
        end else if (w_push && !w_store) begin
            r_overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_W'(1);
                2'b01:   r_level <= r_level - c_LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array carries no reset; emptiness is tracked by r_level alone.
    always_ff @(posedge write_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    assign bus.rd_valid = (r_level != '0);
    assign bus.rd_entry = r_mem[r_rd_ptr];
    assign bus.state    = r_state;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_bus_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_trace_capture
// Purpose  : Self-checking bench for bus_trace_capture (WORD_W=16, DEPTH=16).
//            Trigger matching is table-driven; multi-cycle corner cases are
//            hand-written sequences. Expected entries go to a scoreboard queue
//            as samples are driven and are popped as the FIFO is drained.
// Config   : BUS_TRACE_TIMESTAMP_EN enables the timestamp wrap sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_trace_capture;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 16;
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int c_ENTRY_W = 3 * WORD_W + 16;
`endif

    logic write_clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] r_ts_n = 16'd0;
    logic [3*WORD_W-1:0] sb[$];

    typedef struct {
        logic [15:0] tv;
        logic [15:0] tm;
        logic [15:0] wb;
        logic        hit;
    } vec_t;
    vec_t vecs[7];

    bus_trace_capture_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bif ();

    bus_trace_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .write_clk (write_clk),
        .rst_n     (rst_n),
        .bus       (bif)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3*WORD_W-1:0] mk(input logic [15:0] w);
        return {w, w ^ 16'hA5A5, ~w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge write_clk);
        #1;
        r_ts_n = r_ts_n + 16'd1;
    endtask

    task automatic put(input logic [15:0] w);
        bif.write_bus = w;
        bif.data_bus  = w ^ 16'hA5A5;
        bif.read_bus  = ~w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        r_ts_n = 16'd0;
    endtask

    // Arm, then scramble the config inputs so later behaviour proves latching.
    task automatic arm_cfg(input logic [15:0] v, input logic [15:0] m, input logic [15:0] p);
        bif.trig_value = v;
        bif.trig_mask  = m;
        bif.post_count = p;
        bif.arm = 1'b1;
        step();
        bif.arm = 1'b0;
        bif.trig_value = ~v;
        bif.trig_mask  = 16'hFFFF;
        bif.post_count = 16'd0;
    endtask

    task automatic drain(input string name);
        int guard;
        logic [3*WORD_W-1:0] exp_e;
        guard = 0;
        bif.rd_ready = 1'b1;
        while (sb.size() > 0 && guard < 64) begin
            exp_e = sb.pop_front();
            chk({name, "_valid"}, 64'(bif.rd_valid), 64'd1);
            chk({name, "_data"}, 64'(bif.rd_entry[3*WORD_W-1:0]), 64'(exp_e));
            step();
            guard++;
        end
        if (guard >= 64) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d left expected 0", name, sb.size());
        end
        bif.rd_ready = 1'b0;
        chk({name, "_empty_level"}, 64'(bif.level), 64'd0);
        chk({name, "_empty_valid"}, 64'(bif.rd_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{tv: 16'h1234, tm: 16'hFFFF, wb: 16'h1234, hit: 1'b1};
        vecs[1] = '{tv: 16'h1234, tm: 16'hFFFF, wb: 16'h1235, hit: 1'b0};
        vecs[2] = '{tv: 16'h1234, tm: 16'hFF00, wb: 16'h12AB, hit: 1'b1};
        vecs[3] = '{tv: 16'h1234, tm: 16'hFF00, wb: 16'h13AB, hit: 1'b0};
        vecs[4] = '{tv: 16'h0000, tm: 16'h0000, wb: 16'hBEEF, hit: 1'b1};
        vecs[5] = '{tv: 16'h8000, tm: 16'h8000, wb: 16'h8001, hit: 1'b1};
        vecs[6] = '{tv: 16'hFFFF, tm: 16'h0001, wb: 16'hFFFE, hit: 1'b0};

        rst_n = 1'b0;
        bif.arm = 1'b0;
        bif.disarm = 1'b0;
        bif.rd_ready = 1'b0;
        bif.trig_value = 16'h0;
        bif.trig_mask = 16'h0;
        bif.post_count = 16'h0;
        put(16'h0);
        step();
        do_reset();

        chk("rst_state", 64'(bif.state), 64'd0);
        chk("rst_level", 64'(bif.level), 64'd0);
        chk("rst_valid", 64'(bif.rd_valid), 64'd0);
        chk("rst_overflow", 64'(bif.overflow), 64'd0);

        // Trigger compare table, post_count=0 so a hit stores exactly one sample.
        for (int i = 0; i < 7; i++) begin
            put(16'h0F0F);
            arm_cfg(vecs[i].tv, vecs[i].tm, 16'd0);
            put(vecs[i].wb);
            if (vecs[i].hit) sb.push_back(mk(vecs[i].wb));
            step();
            chk($sformatf("vec%0d_state", i), 64'(bif.state), vecs[i].hit ? 64'd3 : 64'd1);
            bif.disarm = 1'b1;
            step();
            bif.disarm = 1'b0;
            chk($sformatf("vec%0d_idle", i), 64'(bif.state), 64'd0);
            drain($sformatf("vec%0d", i));
        end

        // Exact match with three post-trigger samples.
        put(16'h0000);
        arm_cfg(16'h1234, 16'hFFFF, 16'd3);
        put(16'h1111); step();
        chk("t2_armed0", 64'(bif.state), 64'd1);
        put(16'h1230); step();
        chk("t2_armed1", 64'(bif.state), 64'd1);
        put(16'h1234); sb.push_back(mk(16'h1234)); step();
        chk("t2_capt0", 64'(bif.state), 64'd2);
        put(16'hAAAA); sb.push_back(mk(16'hAAAA)); step();
        put(16'hBBBB); sb.push_back(mk(16'hBBBB)); step();
        chk("t2_capt2", 64'(bif.state), 64'd2);
        put(16'hCCCC); sb.push_back(mk(16'hCCCC)); step();
        chk("t2_done", 64'(bif.state), 64'd3);
        chk("t2_level", 64'(bif.level), 64'd4);
        put(16'hDDDD); step();
        chk("t2_level_hold", 64'(bif.level), 64'd4);
        drain("t2");

        // Overflow: 21 samples into 16 entries with no pops.
        arm_cfg(16'h0000, 16'h0000, 16'd20);
        for (int i = 0; i < 21; i++) begin
            put(16'h0100 + 16'(i));
            if (i < 16) sb.push_back(mk(16'h0100 + 16'(i)));
            step();
            if (i == 15) begin
                chk("t3_full_level", 64'(bif.level), 64'd16);
                chk("t3_full_noovf", 64'(bif.overflow), 64'd0);
            end
            if (i == 19) chk("t3_still_capt", 64'(bif.state), 64'd2);
        end
        chk("t3_state", 64'(bif.state), 64'd3);
        chk("t3_level", 64'(bif.level), 64'd16);
        chk("t3_overflow", 64'(bif.overflow), 64'd1);
        drain("t3");

        // Full FIFO with simultaneous push and pop.
        arm_cfg(16'h0000, 16'h0000, 16'd20);
        chk("t4_arm_clr_ovf", 64'(bif.overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            put(16'h0200 + 16'(i));
            sb.push_back(mk(16'h0200 + 16'(i)));
            step();
        end
        chk("t4_full", 64'(bif.level), 64'd16);
        for (int i = 16; i < 21; i++) begin
            put(16'h0200 + 16'(i));
            sb.push_back(mk(16'h0200 + 16'(i)));
            bif.rd_ready = 1'b1;
            chk($sformatf("t4_pop%0d", i), 64'(bif.rd_entry[3*WORD_W-1:0]), 64'(sb.pop_front()));
            step();
            chk($sformatf("t4_level%0d", i), 64'(bif.level), 64'd16);
        end
        bif.rd_ready = 1'b0;
        chk("t4_state", 64'(bif.state), 64'd3);
        chk("t4_overflow", 64'(bif.overflow), 64'd0);
        drain("t4");

        // disarm and arm together while ARMED; stored entry survives.
        put(16'hAAAA);
        arm_cfg(16'hAAAA, 16'hFFFF, 16'd0);
        sb.push_back(mk(16'hAAAA));
        step();
        chk("t5_pre_done", 64'(bif.state), 64'd3);
        put(16'h0000);
        arm_cfg(16'h5555, 16'hFFFF, 16'd7);
        bif.disarm = 1'b1;
        bif.arm = 1'b1;
        bif.trig_mask = 16'h0000;
        put(16'h5555);
        step();
        bif.disarm = 1'b0;
        bif.arm = 1'b0;
        chk("t5_state", 64'(bif.state), 64'd0);
        chk("t5_level", 64'(bif.level), 64'd1);
        step();
        chk("t5_idle_stays", 64'(bif.state), 64'd0);
        drain("t5");

        // Reset mid-capture with 5 stored.
        arm_cfg(16'h0000, 16'h0000, 16'd30);
        for (int i = 0; i < 5; i++) begin put(16'h0300 + 16'(i)); step(); end
        chk("t1_level5", 64'(bif.level), 64'd5);
        chk("t1_capt", 64'(bif.state), 64'd2);
        do_reset();
        chk("t1_state", 64'(bif.state), 64'd0);
        chk("t1_level", 64'(bif.level), 64'd0);
        chk("t1_valid", 64'(bif.rd_valid), 64'd0);
        chk("t1_overflow", 64'(bif.overflow), 64'd0);
        bif.rd_ready = 1'b1;
        step();
        bif.rd_ready = 1'b0;
        chk("empty_pop_level", 64'(bif.level), 64'd0);

        // Reset mid-capture after an overflow.
        arm_cfg(16'h0000, 16'h0000, 16'd30);
        for (int i = 0; i < 18; i++) begin put(16'h0400 + 16'(i)); step(); end
        chk("t1b_ovf", 64'(bif.overflow), 64'd1);
        chk("t1b_capt", 64'(bif.state), 64'd2);
        do_reset();
        chk("t1b_overflow", 64'(bif.overflow), 64'd0);
        chk("t1b_level", 64'(bif.level), 64'd0);
        chk("t1b_state", 64'(bif.state), 64'd0);

`ifdef BUS_TRACE_TIMESTAMP_EN
        // Timestamp wrap across the capture window.
        put(16'h0000);
        arm_cfg(16'h7777, 16'hFFFF, 16'd2);
        while (r_ts_n != 16'hFFFE) step();
        put(16'h7777); step();
        put(16'h0001); step();
        put(16'h0002); step();
        chk("t6_state", 64'(bif.state), 64'd3);
        bif.rd_ready = 1'b1;
        chk("t6_ts0", 64'(bif.rd_entry[c_ENTRY_W-1 -: 16]), 64'hFFFE);
        step();
        chk("t6_ts1", 64'(bif.rd_entry[c_ENTRY_W-1 -: 16]), 64'hFFFF);
        step();
        chk("t6_ts2", 64'(bif.rd_entry[c_ENTRY_W-1 -: 16]), 64'h0000);
        step();
        bif.rd_ready = 1'b0;
        chk("t6_level", 64'(bif.level), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
